bf16_add_arbiter: RTL and testbench
===================================

Name: bf16_add_arbiter

Overview:
Round-robin scheduler that shares one pipelined BF16 `adder` (ports CLK, rst, A, B, O) among NUM_REQ requesters.
- Accepts operand pairs over per-requester valid/ready, registers the granted pair onto the adder inputs, and tracks requester IDs through the adder latency.
- Returns each sum tagged with its requester ID.
- Supports a flush/drain sequence before reconfiguring or powering down the datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
ADD_LATENCY, 1, adder cycles from A/B change to valid O (>=1)
DATA_W, 16, BF16 operand width (fixed 16)

Ports:
CLK  input  1  clock, all logic on posedge
rst  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester operand pair valid
req_ready  output  NUM_REQ  one-hot grant; combinational from req_valid, rr pointer, state
req_a  input  NUM_REQ*DATA_W  operand A, requester i at [i*16 +: 16]
req_b  input  NUM_REQ*DATA_W  operand B, same packing
add_a  output  DATA_W  registered operand to adder A
add_b  output  DATA_W  registered operand to adder B
add_o  input  DATA_W  adder sum O
rsp_valid  output  1  sum on rsp_data valid this cycle
rsp_id  output  $clog2(NUM_REQ)  requester owning rsp_data
rsp_data  output  DATA_W  = add_o (combinational passthrough)
flush  input  1  level; request drain
flush_done  output  1  pipeline empty while draining
busy  output  1  any op in flight

Behaviour:
- Reset: rr pointer=0, state=RUN, add_a=add_b=16'h0000, tag pipeline cleared, rsp_valid=0, rsp_id=0, flush_done=0, busy=0, req_ready=0 during the rst cycle.
- Arbitration in RUN: grant the lowest index i >= ptr with req_valid[i], wrapping modulo NUM_REQ. At most one req_ready bit high. req_ready=0 when no req_valid.
- Handshake: req_valid[i]&req_ready[i] at edge T.
  - Pointer becomes (i+1) mod NUM_REQ.
  - add_a/add_b load req_a[i]/req_b[i], valid in cycle T+1.
  - A tag {v=1,id=i} enters a (1+ADD_LATENCY)-deep shift register.
- No handshake: add_a/add_b load 16'h0000 and tag v=0, giving deterministic idle inputs. Pointer holds.
- Response: rsp_valid/rsp_id come from the tag pipeline tail, in cycle T+1+ADD_LATENCY. Throughput is 1 op/cycle.
  - There is no response backpressure; requesters must sink rsp every cycle.
- Requester rules: once req_valid is asserted, it must be held with stable operands until ready. The arbiter never revokes a grant within a cycle.
- busy = OR of all tag valid bits.
- FSM:
  - RUN: issue normally. flush=1 -> DRAIN, with no grant in the same cycle (req_ready gated by flush).
  - DRAIN: req_ready=0. When busy==0 -> DONE.
  - DONE: flush_done=1, req_ready=0. flush=0 -> RUN next cycle, pointer retained.
- flush asserted with nothing in flight: RUN->DRAIN->DONE. flush_done rises 2 cycles after flush.
- flush deasserted during DRAIN: finish drain, enter DONE for one cycle, then RUN.
- rst mid-operation: in-flight tags are discarded, so no rsp_valid for ops issued before reset. State returns to RUN.
- Pointer wrap: grant at NUM_REQ-1 sets ptr=0.

Optional Feature:
GRANT_COUNT_EN
- Defined: adds output grant_cnt (NUM_REQ*16 bits), a per-requester 16-bit saturating count of handshakes. Cleared by rst. Holds at 16'hFFFF.
- Undefined: port and counters absent. Behaviour otherwise identical.

Decomposition:
- Package bf16_pkg: DATA_W=16, typedef bf16_t (logic [15:0]), BF16_ZERO=16'h0000, enum arb_state_t {RUN, DRAIN, DONE}.
- Sub-module rr_arbiter (NUM_REQ): req vector + pointer -> one-hot grant + encoded index. Purely combinational; pointer register lives in the parent.

Test Plan (ADD_LATENCY=1, NUM_REQ=4, adder instantiated in bench):
1. Single op: req0 A=16'h4040 (3), B=16'h3F80 (1), handshake at T -> rsp_valid at T+2, rsp_id=0, rsp_data=16'h4080 (4).
2. All four requesters valid at the same time, with pairs (3,1), (8,1240)=(16'h4100,16'h449B), (1024,8192)=(16'h4480,16'h4600), (1.25,2.5)=(16'h3FA0,16'h4020) -> grants 0,1,2,3 on consecutive cycles. Responses back-to-back: 16'h4080, 16'h449C, 16'h4610, 16'h4070 with ids 0..3.
3. Fairness: req1 and req3 held continuously -> grants alternate 1,3,1,3. Pointer wrap from 3 to 0 is verified with req0 joining.
4. Flush with 2 ops in flight -> req_ready=0 from the flush cycle. Both responses still arrive. flush_done asserts the cycle after busy falls. Dropping flush resumes grants.
5. Reset mid-stream: rst asserted the cycle after a handshake -> no rsp_valid afterwards, add_a=add_b=16'h0000, pointer=0.
6. GRANT_COUNT_EN: after scenario 2, grant_cnt = 1 per requester. Forcing 65536 grants on req0 saturates its count at 16'hFFFF.

Source files
------------

// File: rtl/bf16_pkg.sv
// Shared types and constants for the BF16 adder arbiter.
package bf16_pkg;

  localparam int DATA_W = 16;

  typedef logic [15:0] bf16_t;

  localparam bf16_t BF16_ZERO = 16'h0000;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/bf16_add_arbiter_rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or after the
// pointer, wrapping modulo NUM_REQ. The pointer register lives in the parent.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);
  import bf16_pkg::*;

  localparam logic [ID_W:0] NREQ_W = (ID_W + 1)'(NUM_REQ);

  logic [ID_W:0]   w_sum  [NUM_REQ];
  logic [ID_W-1:0] w_cand [NUM_REQ];

  // Candidate k is the requester k positions after the pointer.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign w_sum[gi]  = {1'b0, i_ptr} + (ID_W + 1)'(gi);
      assign w_cand[gi] = (w_sum[gi] >= NREQ_W) ? ID_W'(w_sum[gi] - NREQ_W)
                                                : ID_W'(w_sum[gi]);
    end
  endgenerate

  // Scan farthest-first so the nearest requester wins the last assignment.
  always_comb begin
    o_any   = 1'b0;
    o_idx   = '0;
    o_grant = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req[w_cand[k]]) begin
        o_any = 1'b1;
        o_idx = w_cand[k];
      end
    end
    if (o_any) begin
      o_grant[o_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/bf16_add_arbiter.sv
// Round-robin front end sharing one pipelined BF16 adder among NUM_REQ
// requesters, with ID tagging and flush/drain. Optional macro: GRANT_COUNT_EN.
module bf16_add_arbiter #(
  parameter  int NUM_REQ     = 4,
  parameter  int ADD_LATENCY = 1,
  parameter  int DATA_W      = 16,
  localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      CLK,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [DATA_W-1:0]         add_a,
  output logic [DATA_W-1:0]         add_b,
  input  logic [DATA_W-1:0]         add_o,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  input  logic                      flush,
  output logic                      flush_done,
  output logic                      busy
`ifdef GRANT_COUNT_EN
  ,
  output logic [NUM_REQ*16-1:0]     grant_cnt
`endif
);
  import bf16_pkg::*;

  localparam logic [1:0] S_RUN   = RUN;
  localparam logic [1:0] S_DRAIN = DRAIN;
  localparam logic [1:0] S_DONE  = DONE;

  logic [1:0]         r_state;
  logic [1:0]         w_state_next;
  logic [ID_W-1:0]    r_ptr;
  logic [ID_W-1:0]    w_ptr_next;
  bf16_t              r_add_a;
  bf16_t              r_add_b;
  logic [ADD_LATENCY:0] r_tag_v;
  logic [ID_W-1:0]    r_tag_id [ADD_LATENCY+1];

  logic               w_issue_en;
  logic [NUM_REQ-1:0] w_req_masked;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_idx;
  logic               w_any;
  logic               w_busy;
  logic [DATA_W-1:0]  w_sel_a;
  logic [DATA_W-1:0]  w_sel_b;

  // Flush blocks issue in the very cycle it is raised, as does reset.
  assign w_issue_en   = (r_state == S_RUN) && !flush && !rst;
  assign w_req_masked = req_valid & {NUM_REQ{w_issue_en}};

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .i_req   (w_req_masked),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign req_ready  = w_grant;
  assign w_sel_a    = req_a[w_idx*DATA_W +: DATA_W];
  assign w_sel_b    = req_b[w_idx*DATA_W +: DATA_W];
  assign w_ptr_next = (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
  assign w_busy     = |r_tag_v;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_RUN:   if (flush)   w_state_next = S_DRAIN;
      S_DRAIN: if (!w_busy) w_state_next = S_DONE;
      S_DONE:  if (!flush)  w_state_next = S_RUN;
      default:              w_state_next = S_RUN;
    endcase
  end

  // Idle cycles drive zeros so the adder sees deterministic inputs.
  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state <= S_RUN;
      r_ptr   <= '0;
      r_add_a <= BF16_ZERO;
      r_add_b <= BF16_ZERO;
    end else begin
      r_state <= w_state_next;
      if (w_any) begin
        r_ptr   <= w_ptr_next;
        r_add_a <= w_sel_a;
        r_add_b <= w_sel_b;
      end else begin
        r_add_a <= BF16_ZERO;
        r_add_b <= BF16_ZERO;
      end
    end
  end

  // Tag stage 0 lines up with add_a/add_b; the tail lines up with add_o.
  always_ff @(posedge CLK) begin
    if (rst) begin
      for (int s = 0; s <= ADD_LATENCY; s++) begin
        r_tag_v[s]  <= 1'b0;
        r_tag_id[s] <= '0;
      end
    end else begin
      r_tag_v[0]  <= w_any;
      r_tag_id[0] <= w_any ? w_idx : '0;
      for (int s = 1; s <= ADD_LATENCY; s++) begin
        r_tag_v[s]  <= r_tag_v[s-1];
        r_tag_id[s] <= r_tag_id[s-1];
      end
    end
  end

  assign add_a      = r_add_a;
  assign add_b      = r_add_b;
  assign rsp_valid  = r_tag_v[ADD_LATENCY];
  assign rsp_id     = r_tag_id[ADD_LATENCY];
  assign rsp_data   = add_o;
  assign busy       = w_busy;
  assign flush_done = (r_state == S_DONE);

`ifdef GRANT_COUNT_EN
  logic [15:0] r_grant_cnt [NUM_REQ];

  always_ff @(posedge CLK) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst) begin
        r_grant_cnt[i] <= '0;
      end else if (w_grant[i] && (r_grant_cnt[i] != 16'hFFFF)) begin
        r_grant_cnt[i] <= r_grant_cnt[i] + 16'd1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt_out
      assign grant_cnt[gi*16 +: 16] = r_grant_cnt[gi];
    end
  endgenerate
`endif

endmodule

// File: tb/tb_bf16_add_arbiter.sv
// Directed bench for bf16_add_arbiter with a behavioural one-cycle BF16 adder
// and a scoreboard of expected tagged responses.
module tb_bf16_add_arbiter;

  localparam int NREQ = 4;
  localparam int LAT  = 1;

  logic        CLK;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic [15:0] add_o;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_data;
  logic        flush;
  logic        flush_done;
  logic        busy;
`ifdef GRANT_COUNT_EN
  logic [63:0] grant_cnt;
`endif

  bf16_add_arbiter #(
    .NUM_REQ     (NREQ),
    .ADD_LATENCY (LAT),
    .DATA_W      (16)
  ) dut (
    .CLK        (CLK),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_o      (add_o),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .flush      (flush),
    .flush_done (flush_done),
    .busy       (busy)
`ifdef GRANT_COUNT_EN
    ,
    .grant_cnt  (grant_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic real bf16_to_real(input logic [15:0] x);
    logic [63:0] d;
    if (x[14:7] == 8'd0) return 0.0;
    d = {x[15], 11'(x[14:7]) + 11'd896, x[6:0], 45'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [15:0] real_to_bf16(input real r);
    logic [63:0] d;
    logic [14:0] mag;
    int e;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return {d[63], 15'd0};
    e   = int'(d[62:52]) - 896;
    mag = {e[7:0], d[51:45]};
    if (d[44] && ((|d[43:0]) || d[45])) mag = mag + 15'd1;
    return {d[63], mag};
  endfunction

  // One-cycle adder model standing in for the shared BF16 adder.
  always @(posedge CLK) begin
    add_o <= real_to_bf16(bf16_to_real(add_a) + bf16_to_real(add_b));
  end

  typedef struct {
    int          due;
    logic [1:0]  id;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] exp_sum [NREQ];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  bit          mon_en  = 1'b0;
  bit          quiet   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Response checker and handshake recorder, sampled mid-cycle.
  always @(negedge CLK) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_data", 32'(rsp_data), 32'(e.data));
        if (!quiet) $display("[TB] rsp cyc=%0d id=%0d data=%h", cyc, rsp_id, rsp_data);
      end else begin
        check("rsp_idle", 32'(rsp_valid), 32'd0);
      end
      if (rst) begin
        sb.delete();
      end else if (|(req_valid & req_ready)) begin
        exp_t n;
        n.id = 2'd0;
        for (int i = 0; i < NREQ; i++) if (req_valid[i] && req_ready[i]) n.id = 2'(i);
        n.due  = cyc + 1 + LAT;
        n.data = exp_sum[n.id];
        sb.push_back(n);
        if (!quiet) $display("[TB] issue cyc=%0d id=%0d", cyc, n.id);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] s);
    req_a[i*16 +: 16] = a;
    req_b[i*16 +: 16] = b;
    exp_sum[i] = s;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [3:0] gnt_tab [4];

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    for (int i = 0; i < NREQ; i++) exp_sum[i] = '0;
    repeat (2) tick();
    req_valid = 4'hF;
    #1 check("rst_ready", 32'(req_ready), 32'h0);
    tick();
    req_valid = '0; rst = 1'b0;
    #1;
    check("rst_add_a", 32'(add_a), 32'h0);
    check("rst_add_b", 32'(add_b), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_id", 32'(rsp_id), 32'h0);
    check("rst_flush_done", 32'(flush_done), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    mon_en = 1'b1;

    // Single op on requester 0: 3 + 1 = 4.
    set_op(0, 16'h4040, 16'h3F80, 16'h4080);
    req_valid = 4'b0001;
    #1 check("s1_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    #1;
    check("s1_add_a", 32'(add_a), 32'h4040);
    check("s1_add_b", 32'(add_b), 32'h3F80);
    check("s1_busy", 32'(busy), 32'h1);
    tick();
    #1;
    check("s1_rsp_valid", 32'(rsp_valid), 32'h1);
    check("s1_rsp_data", 32'(rsp_data), 32'h4080);
    tick();
    #1;
    check("s1_idle_busy", 32'(busy), 32'h0);
    check("s1_idle_add_a", 32'(add_a), 32'h0);

    // All four at once from pointer 0.
    do_reset();
    set_op(0, 16'h4040, 16'h3F80, 16'h4080);
    set_op(1, 16'h4100, 16'h449B, 16'h449C);
    set_op(2, 16'h4480, 16'h4600, 16'h4610);
    set_op(3, 16'h3FA0, 16'h4020, 16'h4070);
    gnt_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    req_valid = 4'hF;
    for (int k = 0; k < 4; k++) begin
      #1 check("s2_grant", 32'(req_ready), 32'(gnt_tab[k]));
      tick();
      req_valid = req_valid & ~gnt_tab[k];
    end
    repeat (4) tick();
`ifdef GRANT_COUNT_EN
    check("s6_cnt_after_s2", grant_cnt, {16'd1, 16'd1, 16'd1, 16'd1});
`endif

    // Fairness between 1 and 3, then requester 0 joins across the wrap.
    set_op(0, 16'h4000, 16'h4000, 16'h4080);
    req_valid = 4'b1010;
    gnt_tab = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
    for (int k = 0; k < 4; k++) begin
      #1 check("s3_alt", 32'(req_ready), 32'(gnt_tab[k]));
      tick();
    end
    req_valid = 4'b1011;
    gnt_tab = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
    for (int k = 0; k < 4; k++) begin
      #1 check("s3_wrap", 32'(req_ready), 32'(gnt_tab[k]));
      tick();
    end
    req_valid = '0;
    repeat (3) tick();

    // Flush with two ops in flight; pointer is 1 here.
    req_valid = 4'b1100;
    #1 check("s4_g2", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'b1000;
    #1 check("s4_g3", 32'(req_ready), 32'b1000);
    tick();
    req_valid = 4'b0001; flush = 1'b1;
    #1;
    check("s4_gate", 32'(req_ready), 32'h0);
    check("s4_busy0", 32'(busy), 32'h1);
    tick();
    #1;
    check("s4_drain_ready", 32'(req_ready), 32'h0);
    check("s4_busy1", 32'(busy), 32'h1);
    check("s4_done_early", 32'(flush_done), 32'h0);
    tick();
    #1;
    check("s4_busy_low", 32'(busy), 32'h0);
    check("s4_done_notyet", 32'(flush_done), 32'h0);
    tick();
    #1;
    check("s4_done", 32'(flush_done), 32'h1);
    flush = 1'b0;
    #1 check("s4_done_ready", 32'(req_ready), 32'h0);
    tick();
    #1;
    check("s4_resume_done", 32'(flush_done), 32'h0);
    check("s4_resume_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    repeat (3) tick();

    // Flush with nothing in flight: done two cycles later.
    flush = 1'b1;
    #1 check("s4e_c0", 32'(flush_done), 32'h0);
    tick();
    #1 check("s4e_c1", 32'(flush_done), 32'h0);
    tick();
    #1 check("s4e_c2", 32'(flush_done), 32'h1);
    flush = 1'b0;
    tick();
    #1 check("s4e_run", 32'(flush_done), 32'h0);

    // Reset the cycle after a handshake; the op must never respond.
    req_valid = 4'b0010;
    #1 check("s5_grant", 32'(req_ready), 32'b0010);
    tick();
    rst = 1'b1; req_valid = '0;
    tick();
    rst = 1'b0;
    #1;
    check("s5_add_a", 32'(add_a), 32'h0);
    check("s5_add_b", 32'(add_b), 32'h0);
    check("s5_busy", 32'(busy), 32'h0);
    check("s5_rsp_valid", 32'(rsp_valid), 32'h0);
    req_valid = 4'b1010;
    #1 check("s5_ptr0", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    repeat (4) tick();

`ifdef GRANT_COUNT_EN
    // Saturation of requester 0's grant counter.
    do_reset();
    quiet = 1'b1;
    req_valid = 4'b0001;
    repeat (65534) tick();
    #1 check("s6_cnt_fffe", 32'(grant_cnt[15:0]), 32'hFFFE);
    repeat (2) tick();
    #1 check("s6_cnt_sat", 32'(grant_cnt[15:0]), 32'hFFFF);
    tick();
    #1 check("s6_cnt_hold", 32'(grant_cnt[15:0]), 32'hFFFF);
    check("s6_cnt_others", 32'(grant_cnt[63:16] == 48'd0), 32'h1);
    req_valid = '0;
    repeat (3) tick();
    quiet = 1'b0;
`endif

    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
